hex_message_scroller: RTL and testbench
=======================================

// Module: hex_message_scroller
// PURPOSE
//  Parametrised, self-timed successor to the fixed 6-display, KEY-selected message rotator.
//  Holds an NUM_DISP-character message of CHAR_W-bit codes and rotates it across NUM_DISP
//  7-seg displays. Rotation is driven either by an internal prescaled tick or by a manual step pulse.
//  Direction, pause and reload are run-time controls. Sits between board switches/keys and HEX outputs.
// PARAMETERS
//  NUM_DISP  6    number of displays / message characters (2..16)
//  CHAR_W    3    bits per character code (3..4)
//  TICK_DIV  50000000  clk cycles per automatic rotation step (>=2)
// PORTS
//  clk        in   1                  system clock, all state on rising edge
//  resetn     in   1                  asynchronous, active-low reset
//  load       in   1                  1-cycle pulse: capture msg_in, restart scroll
//  msg_in     in   NUM_DISP*CHAR_W    message; char 0 = msg_in[top CHAR_W bits]
//  run        in   1                  1 = auto-rotate on prescaler tick, 0 = paused
//  dir        in   1                  0 = scroll left (offset+1), 1 = scroll right (offset-1)
//  step       in   1                  1-cycle pulse: one manual rotation step (any run value)
//  offset     out  clog2(NUM_DISP)    current rotation offset, 0..NUM_DISP-1
//  disp_chars out  NUM_DISP*CHAR_W    registered char per display; display 0 (leftmost) = top slice
//  hex_segs   out  NUM_DISP*7         active-low segments {g..a} per display, display 0 = top 7 bits
//  tick       out  1                  1-cycle pulse on prescaler terminal count
// BEHAVIOUR
//  - Reset (async, resetn=0): msg buffer=0, offset=0, prescaler=0, disp_chars=0, tick=0;
//    hex_segs therefore = 7'h47 on every display. Deassertion takes effect on next edge.
//  - Prescaler: counts 0..TICK_DIV-1 while run=1; holds its value while run=0.
//    tick=1 for exactly the cycle after the count wraps TICK_DIV-1 -> 0 (registered).
//  - Step event = tick OR step. Tick and step in the same cycle = ONE step, never two.
//  - On a step event: offset = (offset+1) mod NUM_DISP if dir=0, else (offset-1) mod NUM_DISP.
//    Wrap-around is explicit: NUM_DISP-1 -> 0 (left), 0 -> NUM_DISP-1 (right).
//    Non-power-of-2 NUM_DISP must never reach offset >= NUM_DISP.
//  - disp_chars[d] = msg[(d+offset) mod NUM_DISP]; registered on the same edge offset updates,
//    i.e. a step pulse sampled at edge k is visible on disp_chars/offset after edge k.
//  - hex_segs: pure combinational decode of disp_chars (no extra latency). Code table:
//    0:7'h47 1:7'h06 2:7'h08 3:7'h0E 4:7'h02 5:7'h18; all other codes -> 7'h7F (blank).
//  - load has priority over step/tick in the same cycle. load: msg<=msg_in, offset<=0,
//    prescaler<=0, disp_chars<=msg_in, and any coincident step/tick is dropped.
//  - dir may change any cycle; it is sampled only on a step event.
//  - Clearing run mid-count freezes the prescaler. Setting run again resumes from the held count,
//    not from 0.
//  - Reset asserted mid-scroll returns all state to reset values immediately (async).
//  - No handshake back-pressure; every pulse input is acted on in the cycle it is sampled high.
//    A held-high step steps every cycle.
// STRUCTURE
//  - Shared package hex_scroll_pkg:
//    - character code localparams CH_0..CH_5
//    - SEG_BLANK = 7'h7F
//    - function seg_of(code) holding the code table above
//  - One sub-module: seg7_char_decoder (CHAR_W in, 7 out, combinational, uses seg_of).
//    Instantiate NUM_DISP copies via generate.
//  - Top holds prescaler, offset counter, msg register and rotate mux (generate loop with modulo index).
// TESTING  (bench uses NUM_DISP=6, CHAR_W=3, TICK_DIV=4)
//  - Reset: resetn=0 mid-run -> offset=0, disp_chars=18'h0, every hex_segs digit=7'h47, tick=0, same cycle.
//  - Load 18'o012345, run=0 -> disp_chars=18'o012345, hex = 47,06,08,0E,02,18; no change for 20 cycles.
//  - run=1, dir=0 -> tick every 4 cycles. Offsets 1,2,3,4,5,0; offset=1 gives disp_chars=18'o123450.
//  - dir=1 from offset 0, one step pulse -> offset=5, disp_chars=18'o501234.
//    step coincident with tick -> offset changes by exactly 1.
//  - load pulse same cycle as step, at offset 3 -> offset=0 and disp_chars=msg_in; no step applied.
//  - Load code 3'b110 in char 2 -> hex digit 2 = 7'h7F. Toggle run off at prescaler=2 for 10 cycles,
//    then on -> next tick exactly 2 cycles later.

Source files
------------

// File: rtl/hex_scroll_pkg.sv
// Shared character codes and the 7-segment code table for the message scroller.
package hex_scroll_pkg;

  localparam logic [3:0] CH_0 = 4'd0;
  localparam logic [3:0] CH_1 = 4'd1;
  localparam logic [3:0] CH_2 = 4'd2;
  localparam logic [3:0] CH_3 = 4'd3;
  localparam logic [3:0] CH_4 = 4'd4;
  localparam logic [3:0] CH_5 = 4'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments {g..a}; codes outside the table blank the digit.
  function automatic logic [6:0] seg_of(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      CH_0:    s = 7'h47;
      CH_1:    s = 7'h06;
      CH_2:    s = 7'h08;
      CH_3:    s = 7'h0E;
      CH_4:    s = 7'h02;
      CH_5:    s = 7'h18;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_char_decoder.sv
// Combinational decode of one character code to active-low 7-segment drive.
module seg7_char_decoder
  import hex_scroll_pkg::*;
#(
  parameter int CHAR_W = 3
) (
  input  logic [CHAR_W-1:0] code,
  output logic [6:0]        segs
);

  assign segs = seg_of(4'(code));

endmodule

// File: rtl/hex_message_scroller.sv
// Rotates a NUM_DISP-character message across NUM_DISP 7-seg displays, driven by
// an internal prescaler tick or a manual step pulse.
module hex_message_scroller
  import hex_scroll_pkg::*;
#(
  parameter int NUM_DISP = 6,
  parameter int CHAR_W   = 3,
  parameter int TICK_DIV = 50000000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         load,
  input  logic [NUM_DISP*CHAR_W-1:0]   msg_in,
  input  logic                         run,
  input  logic                         dir,
  input  logic                         step,
  output logic [$clog2(NUM_DISP)-1:0]  offset,
  output logic [NUM_DISP*CHAR_W-1:0]   disp_chars,
  output logic [NUM_DISP*7-1:0]        hex_segs,
  output logic                         tick
);

  localparam int OFF_W = $clog2(NUM_DISP);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(NUM_DISP-1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV-1);

  // Packed slot NUM_DISP-1 is the top slice, i.e. char 0 / display 0.
  logic [NUM_DISP-1:0][CHAR_W-1:0] msg_q, disp_q, chr, rot;
  logic [NUM_DISP-1:0][6:0]        segs;
  logic [CNT_W-1:0]                cnt_q;
  logic [OFF_W-1:0]                off_q, off_step;
  logic                            tick_q, step_evt;

  // A coincident tick and step collapse into a single event.
  assign step_evt = tick_q | step;

  always_comb begin
    if (!dir) off_step = (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
    else      off_step = (off_q == '0) ? OFF_MAX : off_q - 1'b1;
  end

  generate
    for (genvar d = 0; d < NUM_DISP; d++) begin : g_disp
      logic [OFF_W:0]   sum;
      logic [OFF_W-1:0] src;

      assign chr[d] = msg_q[NUM_DISP-1-d];

      // d+offset < 2*NUM_DISP, so one conditional subtract gives the modulo.
      always_comb begin
        sum = (OFF_W+1)'(d) + {1'b0, off_step};
        if (sum >= (OFF_W+1)'(NUM_DISP)) sum = sum - (OFF_W+1)'(NUM_DISP);
        src = sum[OFF_W-1:0];
      end

      assign rot[NUM_DISP-1-d] = chr[src];

      seg7_char_decoder #(.CHAR_W(CHAR_W)) u_dec (
        .code (disp_q[d]),
        .segs (segs[d])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      msg_q  <= '0;
      disp_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (load) begin
      msg_q  <= msg_in;
      disp_q <= msg_in;
      off_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      if (run) begin
        cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        tick_q <= (cnt_q == CNT_MAX);
      end else begin
        tick_q <= 1'b0;
      end
      if (step_evt) begin
        off_q  <= off_step;
        disp_q <= rot;
      end
    end
  end

  assign offset     = off_q;
  assign disp_chars = disp_q;
  assign hex_segs   = segs;
  assign tick       = tick_q;

endmodule

// File: tb/tb_hex_message_scroller.sv
// Scoreboard bench for hex_message_scroller with NUM_DISP=6, CHAR_W=3, TICK_DIV=4.
module tb_hex_message_scroller;

  localparam int N  = 6;
  localparam int CW = 3;
  localparam int TD = 4;

  localparam logic [41:0] HEX_ALL47 = {6{7'h47}};
  localparam logic [41:0] HEX_R0    = {7'h47, 7'h06, 7'h08, 7'h0E, 7'h02, 7'h18};
  localparam logic [41:0] HEX_R1    = {7'h06, 7'h08, 7'h0E, 7'h02, 7'h18, 7'h47};
  localparam logic [41:0] HEX_BL    = {7'h47, 7'h06, 7'h7F, 7'h0E, 7'h02, 7'h18};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0, run = 1'b0, dir = 1'b0, step = 1'b0;
  logic [17:0] msg_in = '0;
  logic [2:0]  offset;
  logic [17:0] disp_chars;
  logic [41:0] hex_segs;
  logic        tick;

  always #5 clk = ~clk;

  hex_message_scroller #(.NUM_DISP(N), .CHAR_W(CW), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .msg_in     (msg_in),
    .run        (run),
    .dir        (dir),
    .step       (step),
    .offset     (offset),
    .disp_chars (disp_chars),
    .hex_segs   (hex_segs),
    .tick       (tick)
  );

  typedef struct {
    string       nm;
    logic [2:0]  off;
    logic [17:0] disp;
    logic        tk;
    logic        hchk;
    logic [41:0] hex;
  } exp_t;

  exp_t sbq[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [17:0] rot [6] = '{18'o012345, 18'o123450, 18'o234501,
                           18'o345012, 18'o450123, 18'o501234};

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string nm, input logic [2:0] off, input logic [17:0] disp,
                      input logic tk, input logic hchk = 1'b0, input logic [41:0] hx = '0);
    exp_t e;
    e.nm = nm; e.off = off; e.disp = disp; e.tk = tk; e.hchk = hchk; e.hex = hx;
    sbq.push_back(e);
    ->chk_ev;
  endtask

  // Monitor: drains the expectation queue against the live DUT outputs.
  initial begin
    forever begin
      @(chk_ev);
      while (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        n_cmp++;
        if (offset !== e.off || disp_chars !== e.disp || tick !== e.tk ||
            (e.hchk && hex_segs !== e.hex)) begin
          n_bad++;
          $display("FAIL %s: got off=%0d disp=%o tick=%b hex=%h, want off=%0d disp=%o tick=%b hex=%h(chk=%b)",
                   e.nm, offset, disp_chars, tick, hex_segs, e.off, e.disp, e.tk, e.hex, e.hchk);
        end
      end
    end
  end

  initial begin
    cyc(2);
    push("reset_init", 3'd0, 18'o0, 1'b0, 1'b1, HEX_ALL47);
    resetn = 1'b1;
    cyc();

    msg_in = 18'o012345; load = 1'b1;
    cyc();
    load = 1'b0;
    push("load", 3'd0, rot[0], 1'b0, 1'b1, HEX_R0);
    cyc(20);
    push("hold20", 3'd0, rot[0], 1'b0, 1'b1, HEX_R0);

    run = 1'b1; dir = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc((k == 1) ? 3 : 2);
      push("pre_tick", 3'((k - 1) % 6), rot[(k - 1) % 6], 1'b0);
      cyc();
      push("tick", 3'((k - 1) % 6), rot[(k - 1) % 6], 1'b1);
      cyc();
      push("auto_step", 3'(k % 6), rot[k % 6], 1'b0, k == 1, HEX_R1);
    end
    run = 1'b0;

    dir = 1'b1; step = 1'b1;
    cyc();
    step = 1'b0;
    push("step_right_wrap", 3'd5, rot[5], 1'b0);

    run = 1'b1;
    cyc(2);
    push("pre_coinc", 3'd5, rot[5], 1'b0);
    cyc();
    push("tick_coinc", 3'd5, rot[5], 1'b1);
    step = 1'b1;
    cyc();
    step = 1'b0; run = 1'b0;
    push("coinc_single", 3'd4, rot[4], 1'b0);

    step = 1'b1;
    cyc();
    step = 1'b0;
    push("step_right", 3'd3, rot[3], 1'b0);

    msg_in = 18'o016345; load = 1'b1; step = 1'b1;
    cyc();
    load = 1'b0; step = 1'b0;
    push("load_vs_step", 3'd0, 18'o016345, 1'b0, 1'b1, HEX_BL);
    cyc();
    push("load_hold", 3'd0, 18'o016345, 1'b0, 1'b1, HEX_BL);

    run = 1'b1;
    cyc(2);
    run = 1'b0;
    cyc(10);
    push("frozen", 3'd0, 18'o016345, 1'b0);
    run = 1'b1;
    cyc();
    push("resume_1", 3'd0, 18'o016345, 1'b0);
    cyc();
    push("resume_tick", 3'd0, 18'o016345, 1'b1);
    run = 1'b0;
    cyc();
    push("resume_step", 3'd5, 18'o501634, 1'b0);

    dir = 1'b0; step = 1'b1;
    cyc();
    push("held_step_0", 3'd0, 18'o016345, 1'b0);
    cyc();
    push("held_step_1", 3'd1, 18'o163450, 1'b0);
    cyc();
    push("held_step_2", 3'd2, 18'o634501, 1'b0);
    step = 1'b0;

    run = 1'b1;
    cyc(2);
    resetn = 1'b0;
    #1;
    push("async_reset", 3'd0, 18'o0, 1'b0, 1'b1, HEX_ALL47);
    cyc();
    push("reset_held", 3'd0, 18'o0, 1'b0, 1'b1, HEX_ALL47);
    resetn = 1'b1; run = 1'b0;
    cyc();

    #2;
    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
